fsm_sw_seq: RTL and testbench

Switch-code sequencer that drives the 3-bit `sw` input of the switch/LED state machine (`fsm_led`) through a fixed walk: idle→st1→st2→st3→st4→st3→idle. It holds each code for a programmable time, reads back the `led` output from the state machine, and reports completion. It is the stimulus-side counterpart of `fsm_led`, used on-board in place of manual switches and in self-test builds.

---
 rtl/fsm_sw_pkg.sv | 24 ++
 rtl/fsm_sw_seq_rom.sv | 24 ++
 rtl/fsm_sw_seq.sv | 139 +++++++++++++
 tb/tb_fsm_sw_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_sw_pkg.sv
// Shared types and constants for the switch-code sequencer.
// The sequence codes drive fsm_led's sw input and also serve as the expected
// led readback values.
package fsm_sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned SEQ_LEN   = 6;
  localparam logic [2:0]  LAST_STEP = 3'(SEQ_LEN - 1);

  // Walk: st1, st2, st3, st4, st3, idle
  localparam logic [2:0] SEQ_CODE_0 = 3'b001;
  localparam logic [2:0] SEQ_CODE_1 = 3'b010;
  localparam logic [2:0] SEQ_CODE_2 = 3'b100;
  localparam logic [2:0] SEQ_CODE_3 = 3'b111;
  localparam logic [2:0] SEQ_CODE_4 = 3'b100;
  localparam logic [2:0] SEQ_CODE_5 = 3'b000;

endpackage

// File: rtl/fsm_sw_seq_rom.sv
// Combinational step-index to switch-code lookup.
// Indices outside 0..5 return 000.
module fsm_sw_seq_rom
  import fsm_sw_pkg::*;
(
  input  logic [2:0] idx,
  output logic [2:0] code
);

  // Fixed walk table
  always_comb begin
    code = '0;
    case (idx)
      3'd0:    code = SEQ_CODE_0;
      3'd1:    code = SEQ_CODE_1;
      3'd2:    code = SEQ_CODE_2;
      3'd3:    code = SEQ_CODE_3;
      3'd4:    code = SEQ_CODE_4;
      3'd5:    code = SEQ_CODE_5;
      default: code = '0;
    endcase
  end

endmodule

// File: rtl/fsm_sw_seq.sv
// Switch-code sequencer: walks fsm_led's sw input through
// 001,010,100,111,100,000, holding each code HOLD_CYC cycles plus one
// readback cycle, then pulses done.
// Optional readback compare (sticky err) enabled by FSM_SW_SEQ_CHECK_EN.
module fsm_sw_seq #(
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] led,
  output logic [2:0] sw,
  output logic       busy,
  output logic       done,
  output logic [2:0] step
`ifdef FSM_SW_SEQ_CHECK_EN
  ,
  output logic       err
`endif
);
  import fsm_sw_pkg::*;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] step_n;
  logic       start_acc;
  logic [2:0] code_n;
  logic [2:0] sw_n;
  logic       busy_n;
  logic       done_n;

  // Outputs are registered from the next-state values so sw/busy change on
  // the same edge that enters DRIVE.
  fsm_sw_seq_rom u_rom_drive (
    .idx  (step_n),
    .code (code_n)
  );

  // Next-state, hold counter and step sequencing
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    step_n    = step;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        step_n = '0;
        cnt_n  = '0;
        if (start) begin
          state_n   = DRIVE;
          start_acc = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == HOLD_LAST) state_n = CHECK;
        else                  cnt_n   = cnt + 8'd1;
      end
      CHECK: begin
        if (step == LAST_STEP) begin
          state_n = DONE;
        end else begin
          state_n = DRIVE;
          step_n  = step + 3'd1;
          cnt_n   = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        step_n  = '0;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        step_n  = '0;
        cnt_n   = '0;
      end
    endcase
    // Unreachable step values 6/7 abort to IDLE
    if (step > LAST_STEP) begin
      state_n   = IDLE;
      step_n    = '0;
      cnt_n     = '0;
      start_acc = 1'b0;
    end
  end

  // Output values to register alongside the next state
  always_comb begin
    sw_n   = '0;
    busy_n = 1'b0;
    done_n = 1'b0;
    if (state_n == DRIVE || state_n == CHECK) begin
      sw_n   = code_n;
      busy_n = 1'b1;
    end
    if (state_n == DONE) done_n = 1'b1;
  end

  // State, counter, step and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= '0;
      sw    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      step  <= step_n;
      sw    <= sw_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

`ifdef FSM_SW_SEQ_CHECK_EN
  logic [2:0] code_exp;

  fsm_sw_seq_rom u_rom_expect (
    .idx  (step),
    .code (code_exp)
  );

  // Sticky readback error, cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err <= 1'b0;
    else if (start_acc)                          err <= 1'b0;
    else if (state == CHECK && led != code_exp)  err <= 1'b1;
  end
`else
  logic unused_led;
  assign unused_led = ^{led, start_acc};
`endif

endmodule

// File: tb/tb_fsm_sw_seq.sv
// Self-checking bench for fsm_sw_seq (HOLD_CYC=4 and HOLD_CYC=2 instances).
// led is produced by a registered follower of sw standing in for fsm_led.
module tb_fsm_sw_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_4, start_2;
  logic [2:0] led_4, led_2;
  logic       force0;
  logic [2:0] sw_4, sw_2, step_4, step_2;
  logic       busy_4, busy_2, done_4, done_2;
`ifdef FSM_SW_SEQ_CHECK_EN
  logic       err_4, err_2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_sw_seq #(.HOLD_CYC(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_4),
    .led   (led_4),
    .sw    (sw_4),
    .busy  (busy_4),
    .done  (done_4),
    .step  (step_4)
`ifdef FSM_SW_SEQ_CHECK_EN
    ,
    .err   (err_4)
`endif
  );

  fsm_sw_seq #(.HOLD_CYC(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_2),
    .led   (led_2),
    .sw    (sw_2),
    .busy  (busy_2),
    .done  (done_2),
    .step  (step_2)
`ifdef FSM_SW_SEQ_CHECK_EN
    ,
    .err   (err_2)
`endif
  );

  // Stand-in for fsm_led: led follows sw one cycle later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_4 <= 3'b000;
      led_2 <= 3'b000;
    end else begin
      led_4 <= force0 ? 3'b000 : sw_4;
      led_2 <= sw_2;
    end
  end

  typedef struct {
    int         k;
    logic [2:0] sw;
    logic       busy;
    logic       done;
    logic [2:0] step;
  } vec_t;

  vec_t       tbl[12];
  logic [2:0] seq_tab[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done4(input int budget, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done_4) begin
        seen = 1;
        break;
      end
    end
    chk(name, seen, 1);
    cyc();
  endtask

  initial begin
    int ti, busy_cnt, done_cnt, exp_sw;

    // Edge k counted from the first edge that sees start high
    tbl[0]  = '{1,  3'b001, 1'b1, 1'b0, 3'd0};
    tbl[1]  = '{4,  3'b001, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{5,  3'b001, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{6,  3'b010, 1'b1, 1'b0, 3'd1};
    tbl[4]  = '{10, 3'b010, 1'b1, 1'b0, 3'd1};
    tbl[5]  = '{11, 3'b100, 1'b1, 1'b0, 3'd2};
    tbl[6]  = '{16, 3'b111, 1'b1, 1'b0, 3'd3};
    tbl[7]  = '{21, 3'b100, 1'b1, 1'b0, 3'd4};
    tbl[8]  = '{26, 3'b000, 1'b1, 1'b0, 3'd5};
    tbl[9]  = '{30, 3'b000, 1'b1, 1'b0, 3'd5};
    tbl[10] = '{31, 3'b000, 1'b0, 1'b1, 3'd5};
    tbl[11] = '{32, 3'b000, 1'b0, 1'b0, 3'd0};
    seq_tab = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b100, 3'b000};

    rst_n   = 1'b0;
    start_4 = 1'b0;
    start_2 = 1'b0;
    force0  = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    chk("rst_sw",   int'(sw_4),   0);
    chk("rst_busy", int'(busy_4), 0);
    chk("rst_done", int'(done_4), 0);
    chk("rst_step", int'(step_4), 0);
`ifdef FSM_SW_SEQ_CHECK_EN
    chk("rst_err",  int'(err_4),  0);
`endif

    // Walk 1: table-driven, looped led
    ti = 0; busy_cnt = 0; done_cnt = 0;
    start_4 = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      cyc();
      if (k == 1) start_4 = 1'b0;
      busy_cnt += int'(busy_4);
      done_cnt += int'(done_4);
      if (ti < 12 && tbl[ti].k == k) begin
        chk($sformatf("w1_sw_k%0d", k),   int'(sw_4),   int'(tbl[ti].sw));
        chk($sformatf("w1_busy_k%0d", k), int'(busy_4), int'(tbl[ti].busy));
        chk($sformatf("w1_done_k%0d", k), int'(done_4), int'(tbl[ti].done));
        chk($sformatf("w1_step_k%0d", k), int'(step_4), int'(tbl[ti].step));
        ti++;
      end
    end
    chk("w1_busy_cycles", busy_cnt, 30);
    chk("w1_done_pulses", done_cnt, 1);
`ifdef FSM_SW_SEQ_CHECK_EN
    chk("w1_err", int'(err_4), 0);
`endif

    // Walk 2: led forced to 000
    force0 = 1'b1;
    start_4 = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k == 1) start_4 = 1'b0;
`ifdef FSM_SW_SEQ_CHECK_EN
      if (k == 5) chk("w2_err_in_check", int'(err_4), 0);
      if (k == 6) chk("w2_err_after_check", int'(err_4), 1);
`endif
      if (k == 31) chk("w2_done", int'(done_4), 1);
    end
    force0 = 1'b0;
`ifdef FSM_SW_SEQ_CHECK_EN
    chk("w2_err_sticky", int'(err_4), 1);
`endif
    start_4 = 1'b1;
    cyc();
    start_4 = 1'b0;
    chk("w2b_sw_first", int'(sw_4), 1);
`ifdef FSM_SW_SEQ_CHECK_EN
    chk("w2b_err_cleared", int'(err_4), 0);
`endif
    wait_done4(40, "w2b_done_seen");
`ifdef FSM_SW_SEQ_CHECK_EN
    chk("w2b_err_end", int'(err_4), 0);
`endif

    // Walk 3: start held high, back-to-back
    start_4 = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      cyc();
      if (k == 31) chk("w3_done_rise", int'(done_4), 1);
      if (k == 32) begin
        chk("w3_done_one_cycle", int'(done_4), 0);
        chk("w3_idle_sw", int'(sw_4), 0);
        chk("w3_idle_busy", int'(busy_4), 0);
      end
      if (k == 33) begin
        chk("w3_restart_sw", int'(sw_4), 1);
        chk("w3_restart_busy", int'(busy_4), 1);
        chk("w3_restart_step", int'(step_4), 0);
      end
    end
    start_4 = 1'b0;
    wait_done4(40, "w3_done_seen");

    // Walk 4: start pulse at step 2 is ignored
    start_4 = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k == 1)  start_4 = 1'b0;
      if (k == 12) start_4 = 1'b1;
      if (k == 13) begin
        start_4 = 1'b0;
        chk("w4_k13_step", int'(step_4), 2);
        chk("w4_k13_sw", int'(sw_4), 4);
      end
      if (k == 14) chk("w4_k14_step", int'(step_4), 2);
      if (k == 16) chk("w4_k16_step", int'(step_4), 3);
      if (k == 21) chk("w4_k21_step", int'(step_4), 4);
      if (k == 26) chk("w4_k26_step", int'(step_4), 5);
      if (k == 31) chk("w4_done", int'(done_4), 1);
      if (k == 32) chk("w4_k32_step", int'(step_4), 0);
    end

    // Walk 5: asynchronous reset at step 3 during DRIVE
    start_4 = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 1) start_4 = 1'b0;
    end
    chk("w5_pre_step", int'(step_4), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("w5_async_sw", int'(sw_4), 0);
    chk("w5_async_busy", int'(busy_4), 0);
    chk("w5_async_step", int'(step_4), 0);
    #3;
    rst_n = 1'b1;
    cyc();
    chk("w5_idle_sw", int'(sw_4), 0);
    start_4 = 1'b1;
    cyc();
    start_4 = 1'b0;
    chk("w5_new_sw", int'(sw_4), 1);
    chk("w5_new_step", int'(step_4), 0);
    chk("w5_new_busy", int'(busy_4), 1);
    wait_done4(40, "w5_done_seen");

    // Walk 6: HOLD_CYC=2, each code held 3 cycles
    busy_cnt = 0;
    start_2 = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      cyc();
      if (k == 1) start_2 = 1'b0;
      busy_cnt += int'(busy_2);
      exp_sw = (k <= 18) ? int'(seq_tab[(k - 1) / 3]) : 0;
      chk($sformatf("h2_sw_k%0d", k), int'(sw_2), exp_sw);
      if (k == 19) chk("h2_done", int'(done_2), 1);
    end
    chk("h2_busy_cycles", busy_cnt, 18);
`ifdef FSM_SW_SEQ_CHECK_EN
    chk("h2_err", int'(err_2), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
